// File: rtl/bsg_fsb_pkg.sv
// Shared definitions for the front-side-bus hop blocks.
//
// Contents:
//   bsg_fsb_src_pass_gp  - source index of the pass-through stream from the previous hop
//   bsg_fsb_src_local_gp - source index of the local node's outbound stream
//   bsg_fsb_cnt_width_gp - width of the per-source transfer counters
//   bsg_fsb_cnt_t        - counter type (wraps modulo 2**bsg_fsb_cnt_width_gp)
package bsg_fsb_pkg;

    localparam int bsg_fsb_src_pass_gp  = 0;
    localparam int bsg_fsb_src_local_gp = 1;
    localparam int bsg_fsb_cnt_width_gp = 16;

    typedef logic [bsg_fsb_cnt_width_gp-1:0] bsg_fsb_cnt_t;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with registered outputs, used as the hop-out output buffer.
//
// Handshake: an input word is written on a rising edge where v_i & ready_o;
// ready_o = ~full and does not look at yumi_i, so a full buffer refuses a new
// word even if the head leaves in the same cycle. The head word leaves on a
// rising edge where yumi_i is high; yumi_i may only be asserted while v_o = 1.
// v_o = ~empty and data_o is the head entry straight from storage, so nothing
// written this cycle is visible before the next edge.
//
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - asynchronous active-high reset, empties the buffer
//   ready_o  - buffer can take a word this cycle
//   data_i   - word to write
//   v_i      - data_i is valid
//   v_o      - head entry present
//   data_o   - head entry
//   yumi_i   - head entry consumed this cycle
//   count    - number of entries held (0..2), for debug visibility
module bsg_two_fifo
    import bsg_fsb_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [1:0]         count
);

    logic [width_p-1:0] mem_r [2];
    logic               wptr_r;
    logic               rptr_r;
    logic [1:0]         count_r;
    logic               enq;
    logic               deq;

    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[rptr_r];
    assign count   = count_r;

    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (enq) wptr_r <= ~wptr_r;
            if (deq) rptr_r <= ~rptr_r;
            count_r <= count_r + 2'(enq) - 2'(deq);
        end
    end

    // Storage needs no reset: an entry is only observed after it is written.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_front_side_bus_hop_out.sv
// Front-side-bus hop-out merge stage. Arbitrates between the pass-through
// stream (source 0) and the local stream (source 1) and places the granted
// word into a two-entry output buffer that drives the outgoing link.
//
// Handshake: source k transfers on a rising edge where v_i[k] & ready_o[k];
// a source holds data steady while valid and not yet transferred, and its
// valid never depends on ready_o. The outgoing word is consumed on a rising
// edge where v_o & ready_i.
//
// Build option: BSG_FSB_HOP_OUT_FIXED_PRIO_EN - when defined, source 0 wins
// every tie (local traffic may starve) and the round-robin bit is absent.
// Default (undefined) is round-robin between the two sources.
//
// Ports:
//   clk_i      - clock, rising edge
//   reset_i    - asynchronous active-high reset
//   v_i[1:0]   - per-source valid (0 pass-through, 1 local)
//   data_i     - source k at bits [k*width_p +: width_p]
//   ready_o    - per-source ready
//   v_o        - output word valid
//   data_o     - output word
//   ready_i    - downstream ready
//   word_cnt_o - per-source 16-bit transfer counters, wrapping, debug only
module bsg_front_side_bus_hop_out
    import bsg_fsb_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [1:0]                 v_i,
    input  logic [2*width_p-1:0]       data_i,
    output logic [1:0]                 ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_i,
    output logic [1:0][bsg_fsb_cnt_width_gp-1:0] word_cnt_o
);

    logic [1:0]         grant;
    logic               fifo_ready;
    logic               fifo_v;
    logic [width_p-1:0] fifo_data;
    logic               take_local;
    logic               yumi;
    logic [1:0]         fifo_count;
    bsg_fsb_cnt_t       word_cnt_r [2];

`ifdef BSG_FSB_HOP_OUT_FIXED_PRIO_EN
    // Pass-through always wins so the ring drains ahead of new local traffic.
    always_comb begin
        grant = '0;
        grant[bsg_fsb_src_pass_gp]  = v_i[bsg_fsb_src_pass_gp];
        grant[bsg_fsb_src_local_gp] = v_i[bsg_fsb_src_local_gp] & ~v_i[bsg_fsb_src_pass_gp];
    end
`else
    // last_r remembers the most recently granted source; on a tie the other
    // source wins. Reset value 1 lets the pass-through take the first tie.
    logic last_r;

    always_comb begin
        grant = '0;
        grant[bsg_fsb_src_pass_gp]  = v_i[bsg_fsb_src_pass_gp]
                                    & (~v_i[bsg_fsb_src_local_gp] | last_r);
        grant[bsg_fsb_src_local_gp] = v_i[bsg_fsb_src_local_gp]
                                    & (~v_i[bsg_fsb_src_pass_gp] | ~last_r);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_r <= 1'b1;
        end else if (fifo_v) begin
            last_r <= take_local;
        end
    end
`endif

    // Reset gating keeps ready low while the buffer is being held empty.
    assign ready_o    = grant & {2{fifo_ready & ~reset_i}};
    assign fifo_v     = |(v_i & ready_o);
    assign take_local = v_i[bsg_fsb_src_local_gp] & ready_o[bsg_fsb_src_local_gp];
    assign fifo_data  = take_local ? data_i[bsg_fsb_src_local_gp*width_p +: width_p]
                                   : data_i[bsg_fsb_src_pass_gp*width_p +: width_p];
    assign yumi       = v_o & ready_i;

    bsg_two_fifo #(.width_p(width_p)) out_buf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (fifo_ready),
        .data_i  (fifo_data),
        .v_i     (fifo_v),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi),
        .count   (fifo_count)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            word_cnt_r[0] <= '0;
            word_cnt_r[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (v_i[k] & ready_o[k]) word_cnt_r[k] <= word_cnt_r[k] + bsg_fsb_cnt_t'(1);
            end
        end
    end

    assign word_cnt_o[0] = word_cnt_r[0];
    assign word_cnt_o[1] = word_cnt_r[1];

    // Occupancy is only useful when probing the buffer from a debugger.
    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out.sv
// Self-checking bench for bsg_front_side_bus_hop_out.
module tb_bsg_front_side_bus_hop_out;

  localparam int W = 16;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic [1:0]       v_i = 2'b00;
  logic [2*W-1:0]   data_i = '0;
  logic [1:0]       ready_o;
  logic             v_o;
  logic [W-1:0]     data_o;
  logic             ready_i = 1'b0;
  logic [1:0][15:0] word_cnt_o;

  always #5 clk = ~clk;

  bsg_front_side_bus_hop_out #(.width_p(W)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .ready_i    (ready_i),
    .word_cnt_o (word_cnt_o)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];     // words accepted but not yet delivered, in order
  logic [W-1:0] out_log[$];   // words delivered
  int           errors = 0;
  int           checks = 0;
  bit           in_reset = 1'b1;
  bit           model_last = 1'b1;
  logic [15:0]  model_cnt [2] = '{16'd0, 16'd0};
  bit   [1:0]   src_v = 2'b00;
  logic [W-1:0] src_d [2] = '{16'd0, 16'd0};
  bit           strict_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which source the rules say should win, given valids and buffer occupancy.
  function automatic logic [1:0] model_grant(input bit [1:0] v);
    if (in_reset || exp_q.size() >= 2 || v == 2'b00) return 2'b00;
`ifdef BSG_FSB_HOP_OUT_FIXED_PRIO_EN
    return v[0] ? 2'b01 : 2'b10;
`else
    if (v == 2'b11) return model_last ? 2'b01 : 2'b10;
    return v;
`endif
  endfunction

  // Monitor: checks output valid against the model buffer and pops on consume.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      check("v_o", v_o, (!in_reset && exp_q.size() > 0));
      if (v_o && ready_i && exp_q.size() > 0) begin
        check("data_o", data_o, exp_q[0]);
        out_log.push_back(data_o);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit [1:0] new_v, input logic [W-1:0] d0,
                      input logic [W-1:0] d1, input bit rdy);
    logic [1:0] g;
    int s;
    if (!src_v[0]) begin src_v[0] = new_v[0]; src_d[0] = d0; end
    if (!src_v[1]) begin src_v[1] = new_v[1]; src_d[1] = d1; end
    v_i     = src_v;
    data_i  = {src_d[1], src_d[0]};
    ready_i = rdy;
    #2;
    g = model_grant(src_v);
    check("ready_o", ready_o & src_v, g);
    if (exp_q.size() >= 2) check("ready_o_full", ready_o, 2'b00);
    if (strict_chk) check("ready_o_exact", ready_o, g);
    @(posedge clk);
    if (g != 2'b00) begin
      s = g[1] ? 1 : 0;
      exp_q.push_back(src_d[s]);
      model_last   = g[1];
      model_cnt[s] = model_cnt[s] + 16'd1;
      src_v[s]     = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && src_v == 2'b00) break;
      step(2'b00, '0, '0, 1'b1);
    end
    check("drain_done", exp_q.size() + int'(src_v), 0);
  endtask

  task automatic check_counters(input string name);
    check({name, "_cnt0"}, word_cnt_o[0], model_cnt[0]);
    check({name, "_cnt1"}, word_cnt_o[1], model_cnt[1]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] tie_exp [4];
  logic [W-1:0] bp_exp [3];
  logic [15:0]  base0, base1;

  initial begin
`ifdef BSG_FSB_HOP_OUT_FIXED_PRIO_EN
    tie_exp = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
`else
    tie_exp = '{16'h1000, 16'h2000, 16'h1001, 16'h2001};
`endif
    bp_exp = '{16'hB000, 16'hB001, 16'hB002};

    // Reset held for 3 cycles with both sources asking.
    @(negedge clk);
    v_i     = 2'b11;
    data_i  = {16'h5555, 16'hAAAA};
    ready_i = 1'b1;
    repeat (3) begin
      #2;
      check("rst_v_o", v_o, 1'b0);
      check("rst_ready_o", ready_o, 2'b00);
      @(negedge clk);
    end
    reset_i  = 1'b0;
    in_reset = 1'b0;
    check_counters("post_reset");

    // First cycle after release: pass-through alone must see ready 01.
    strict_chk = 1'b1;
    step(2'b01, 16'h0001, '0, 1'b1);
    strict_chk = 1'b0;
    drain();

    // Single source, two consecutive words.
    out_log.delete();
    step(2'b10, '0, 16'h00A1, 1'b1);
    step(2'b10, '0, 16'h00A2, 1'b1);
    drain();
    check("single_n", out_log.size(), 2);
    check("single_w0", out_log[0], 16'h00A1);
    check("single_w1", out_log[1], 16'h00A2);

    // Tie: both sources valid continuously.
    out_log.delete();
    base0 = model_cnt[0];
    base1 = model_cnt[1];
    for (int n = 0; n < 4; n++)
      step(2'b11, 16'h1000 + (model_cnt[0] - base0), 16'h2000 + (model_cnt[1] - base1), 1'b1);
    drain();
    check("tie_n", out_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) check("tie_word", out_log[i], tie_exp[i]);

    // Backpressure: third word stalls until the link opens.
    out_log.delete();
    step(2'b01, 16'hB000, '0, 1'b0);
    step(2'b01, 16'hB001, '0, 1'b0);
    step(2'b01, 16'hB002, '0, 1'b0);
    step(2'b00, '0, '0, 1'b0);
    drain();
    check("bp_n", out_log.size(), 3);
    for (int i = 0; i < 3; i++) check("bp_word", out_log[i], bp_exp[i]);
    check_counters("bp");

    // Mid-stream reset with two words buffered.
    step(2'b10, '0, 16'hC000, 1'b0);
    step(2'b10, '0, 16'hC001, 1'b0);
    #1;
    reset_i  = 1'b1;
    in_reset = 1'b1;
    exp_q.delete();
    src_v      = 2'b00;
    v_i        = 2'b00;
    model_last = 1'b1;
    model_cnt  = '{16'd0, 16'd0};
    #1;
    check("async_v_o", v_o, 1'b0);
    check("async_ready_o", ready_o, 2'b00);
    @(posedge clk);
    @(negedge clk);
    reset_i  = 1'b0;
    in_reset = 1'b0;
    repeat (3) step(2'b00, '0, '0, 1'b1);
    check_counters("mid_reset");

    // Counter wrap: 3 local words, then 65536 pass-through words.
    for (int i = 0; i < 3; i++) step(2'b10, '0, 16'(16'hD000 + i), 1'b1);
    drain();
    for (int i = 0; i < 65536; i++) step(2'b01, 16'($urandom), '0, 1'b1);
    drain();
    check("wrap_cnt0", word_cnt_o[0], 16'd0);
    check("wrap_cnt1", word_cnt_o[1], 16'd3);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++)
      step(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
    drain();
    check_counters("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
